// File: rtl/fp8_add_sequencer_if.sv
// Byte-stream, result and adder-side signals of the FP8 add sequencer.
// The slave modport is the sequencer; master is the wrapper/adder side.
interface fp8_add_sequencer_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] res_data;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] add_a;
   logic [7:0] add_b;
   logic [7:0] add_sum;

   modport master (
      output in_data, in_valid, res_ready, add_sum,
      input  in_ready, res_data, res_valid, add_a, add_b
   );

   modport slave (
      input  in_data, in_valid, res_ready, add_sum,
      output in_ready, res_data, res_valid, add_a, add_b
   );
endinterface

// File: rtl/fp8_add_sequencer.sv
// Operand sequencer for an FP8 (1-4-3) adder: collects A then B, waits ADDER_LATENCY, holds result.
// Optional FP8_SEQ_ACCUMULATE_EN feeds the held result back as A for a running sum.
module fp8_add_sequencer #(
   parameter int unsigned ADDER_LATENCY = 1  // legal 1..15
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic                acc_mode,
   output logic                busy,
   output logic [7:0]          op_count,
   fp8_add_sequencer_if.slave  bus
);

   localparam logic [3:0] LatLoad = 4'(ADDER_LATENCY - 1);

   typedef enum logic [1:0] {StIdle, StLoadB, StExec, StHold} state_e;

   state_e     state_q, state_d;
   logic [7:0] add_a_q, add_a_d;
   logic [7:0] add_b_q, add_b_d;
   logic [7:0] res_data_q, res_data_d;
   logic       res_valid_q, res_valid_d;
   logic [7:0] op_count_q, op_count_d;
   logic [3:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         add_a_q     <= 8'h00;
         add_b_q     <= 8'h00;
         res_data_q  <= 8'h00;
         res_valid_q <= 1'b0;
         op_count_q  <= 8'h00;
         cnt_q       <= 4'h0;
      end else begin
         state_q     <= state_d;
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         res_data_q  <= res_data_d;
         res_valid_q <= res_valid_d;
         op_count_q  <= op_count_d;
         cnt_q       <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      add_a_d      = add_a_q;
      add_b_d      = add_b_q;
      res_data_d   = res_data_q;
      res_valid_d  = res_valid_q;
      op_count_d   = op_count_q;
      cnt_d        = cnt_q;
      bus.in_ready = 1'b0;
      // ena low freezes everything, including the byte handshake
      if (ena) begin
         unique case (state_q)
            StIdle: begin
               bus.in_ready = 1'b1;
               if (bus.in_valid) begin
                  add_a_d = bus.in_data;
                  state_d = StLoadB;
               end
            end
            StLoadB: begin
               bus.in_ready = 1'b1;
               if (bus.in_valid) begin
                  add_b_d = bus.in_data;
                  cnt_d   = LatLoad;
                  state_d = StExec;
               end
            end
            StExec: begin
               if (cnt_q != 4'h0) begin
                  cnt_d = cnt_q - 4'h1;
               end else begin
                  res_data_d  = bus.add_sum;
                  res_valid_d = 1'b1;
                  op_count_d  = op_count_q + 8'h01;
                  state_d     = StHold;
               end
            end
            StHold: begin
               if (bus.res_ready) begin
                  res_valid_d = 1'b0;
                  state_d     = StIdle;
`ifdef FP8_SEQ_ACCUMULATE_EN
                  if (acc_mode) begin
                     add_a_d = res_data_q;
                     state_d = StLoadB;
                  end
`endif
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

`ifndef FP8_SEQ_ACCUMULATE_EN
   logic unused_acc_mode;
   assign unused_acc_mode = acc_mode;
`endif

   assign busy          = (state_q != StIdle);
   assign op_count      = op_count_q;
   assign bus.add_a     = add_a_q;
   assign bus.add_b     = add_b_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_valid = res_valid_q;

endmodule

// File: tb/tb_fp8_add_sequencer.sv
// Self-checking bench for fp8_add_sequencer: directed scenarios plus a randomized 256-op run
// scored against a real-arithmetic FP8 (1-4-3, bias 7) adder reference.
module tb_fp8_add_sequencer;

   localparam int unsigned LAT = 3;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic       acc_mode;
   logic       busy;
   logic [7:0] op_count;

   fp8_add_sequencer_if bus ();

   fp8_add_sequencer #(.ADDER_LATENCY(LAT)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .acc_mode (acc_mode),
      .busy     (busy),
      .op_count (op_count),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_cnt = 0;

   // ---------------- FP8 reference arithmetic ----------------
   function automatic real pow2(input int e);
      real r = 1.0;
      if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
      else        for (int i = 0; i < -e; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real fp8_val(input logic [7:0] c);
      int  e = int'(c[6:3]);
      real m = real'(int'(c[2:0])) / 8.0;
      real v;
      if (e == 0) v = m * pow2(-6);
      else        v = (1.0 + m) * pow2(e - 7);
      return c[7] ? -v : v;
   endfunction

   // Exact real sum rounded to nearest FP8 code, ties to even, overflow to infinity.
   function automatic logic [7:0] fp8_add(input logic [7:0] a, input logic [7:0] b);
      real        s, mag, d, best_d;
      logic [7:0] best;
      if (a[6:3] == 4'hf || b[6:3] == 4'hf) return 8'h7f;
      s   = fp8_val(a) + fp8_val(b);
      mag = (s < 0.0) ? -s : s;
      if (mag >= 248.0) return {(s < 0.0), 7'h78};
      best   = 8'h00;
      best_d = mag;
      for (int c = 1; c <= 'h77; c++) begin
         d = fp8_val(8'(c)) - mag;
         if (d < 0.0) d = -d;
         if (d < best_d || (d == best_d && c[0] == 1'b0)) begin
            best   = 8'(c);
            best_d = d;
         end
      end
      if (s < 0.0 && best != 8'h00) best[7] = 1'b1;
      return best;
   endfunction

   function automatic logic [7:0] rand_fp8();
      logic [7:0] x = 8'($urandom);
      if (x[6:3] == 4'hf) x[6:3] = 4'he;
      return x;
   endfunction

   // Adder model: LAT-1 register stages behind the combinational sum, so the sum is
   // valid at the edge the sequencer samples it (LAT edges after the B transfer).
   logic [7:0] sum_now;
   logic [7:0] stage [LAT];
   always_comb sum_now = fp8_add(bus.add_a, bus.add_b);
   always_ff @(posedge clk) begin
      stage[0] <= sum_now;
      for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
   end
   generate
      if (LAT == 1) begin : g_comb
         assign bus.add_sum = sum_now;
      end else begin : g_pipe
         assign bus.add_sum = stage[LAT-2];
      end
   endgenerate

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] d);
      int n = 0;
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) check("send_ready_timeout", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_res(output int n);
      n = 0;
      while (!bus.res_valid && n < 60) begin
         tick();
         n++;
      end
   endtask

   task automatic handshake();
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n   = 1'b1;
      exp_cnt = 0;
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int bp);
      int n;
      bus.res_ready = 1'b0;
      send_byte(a);
      send_byte(b);
      wait_res(n);
      check("rnd_latency", 32'(n), 32'(LAT));
      exp_cnt++;
      check("rnd_data", 32'(bus.res_data), 32'(fp8_add(a, b)));
      check("rnd_op_count", 32'(op_count), 32'(exp_cnt % 256));
      repeat (bp) tick();
      check("rnd_hold", 32'(bus.res_valid), 32'd1);
      handshake();
      check("rnd_release", 32'(busy), 32'd0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      int n;
      rst_n         = 1'b0;
      ena           = 1'b1;
      acc_mode      = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.res_ready = 1'b0;

      // T1 reset / idle
      do_reset();
      check("t1_in_ready", 32'(bus.in_ready), 32'd1);
      check("t1_busy", 32'(busy), 32'd0);
      check("t1_res_valid", 32'(bus.res_valid), 32'd0);
      check("t1_op_count", 32'(op_count), 32'd0);
      check("t1_add_a", 32'(bus.add_a), 32'h00);
      check("t1_add_b", 32'(bus.add_b), 32'h00);

      // T5 mid-op reset in LOAD_B, with ena low to show reset wins
      send_byte(8'h38);
      check("t5_busy_loadb", 32'(busy), 32'd1);
      check("t5_add_a_loaded", 32'(bus.add_a), 32'h38);
      ena   = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      ena   = 1'b1;
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_add_a", 32'(bus.add_a), 32'h00);
      repeat (LAT + 2) tick();
      check("t5_res_valid", 32'(bus.res_valid), 32'd0);
      check("t5_op_count", 32'(op_count), 32'd0);

      // byte offered while ena=0 in IDLE is not consumed
      ena          = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h55;
      repeat (3) tick();
      check("frz_in_ready", 32'(bus.in_ready), 32'd0);
      check("frz_busy", 32'(busy), 32'd0);
      bus.in_valid = 1'b0;
      ena          = 1'b1;
      tick();
      check("frz_not_consumed", 32'(busy), 32'd0);

      // T2 basic add, res_ready already high before res_valid
      bus.res_ready = 1'b1;
      send_byte(8'h38);
      send_byte(8'h40);
      wait_res(n);
      check("t2_latency", 32'(n), 32'(LAT));
      exp_cnt++;
      check("t2_data", 32'(bus.res_data), 32'h44);
      check("t2_op_count", 32'(op_count), 32'(exp_cnt));
      tick();
      bus.res_ready = 1'b0;
      check("t2_valid_drop", 32'(bus.res_valid), 32'd0);
      check("t2_idle", 32'(busy), 32'd0);
      check("t2_in_ready", 32'(bus.in_ready), 32'd1);

      // T3 backpressure with a third byte waiting
      send_byte(8'h40);
      send_byte(8'h40);
      wait_res(n);
      check("t3_latency", 32'(n), 32'(LAT));
      exp_cnt++;
      bus.in_data  = 8'h38;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check("t3_hold_valid", 32'(bus.res_valid), 32'd1);
         check("t3_hold_data", 32'(bus.res_data), 32'h48);
         check("t3_in_ready", 32'(bus.in_ready), 32'd0);
         tick();
      end
      check("t3_a_untouched", 32'(bus.add_a), 32'h40);
      handshake();
      check("t3_valid_drop", 32'(bus.res_valid), 32'd0);
      check("t3_idle_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      check("t3_next_a", 32'(bus.add_a), 32'h38);
      check("t3_busy", 32'(busy), 32'd1);
      send_byte(8'h38);
      wait_res(n);
      exp_cnt++;
      check("t3_second_data", 32'(bus.res_data), 32'h40);
      check("t3_op_count", 32'(op_count), 32'(exp_cnt));
      handshake();

      // T4 ena freeze for 5 cycles in EXEC, then in HOLD
      send_byte(8'h38);
      send_byte(8'h40);
      ena = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("t4_frz_valid", 32'(bus.res_valid), 32'd0);
         check("t4_frz_ready", 32'(bus.in_ready), 32'd0);
         tick();
      end
      ena = 1'b1;
      wait_res(n);
      check("t4_latency", 32'(n + 5), 32'(LAT + 5));
      exp_cnt++;
      check("t4_data", 32'(bus.res_data), 32'h44);
      ena           = 1'b0;
      bus.res_ready = 1'b1;
      repeat (3) tick();
      check("t4_hold_valid", 32'(bus.res_valid), 32'd1);
      check("t4_hold_count", 32'(op_count), 32'(exp_cnt));
      ena = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      check("t4_release", 32'(bus.res_valid), 32'd0);

      // T6 accumulate
      acc_mode = 1'b1;
      send_byte(8'h38);
      send_byte(8'h38);
      wait_res(n);
      exp_cnt++;
      check("t6_first", 32'(bus.res_data), 32'h40);
      handshake();
`ifdef FP8_SEQ_ACCUMULATE_EN
      check("t6_loadb", 32'(busy), 32'd1);
      check("t6_fedback", 32'(bus.add_a), 32'h40);
      acc_mode = 1'b0;
      send_byte(8'h38);
      wait_res(n);
      exp_cnt++;
      check("t6_running", 32'(bus.res_data), 32'h44);
      handshake();
      check("t6_idle", 32'(busy), 32'd0);
`else
      acc_mode = 1'b0;
      check("t6_idle", 32'(busy), 32'd0);
      send_byte(8'h38);
      check("t6_new_a", 32'(bus.add_a), 32'h38);
      repeat (LAT + 1) tick();
      check("t6_no_result", 32'(bus.res_valid), 32'd0);
      send_byte(8'h38);
      wait_res(n);
      exp_cnt++;
      check("t6_second", 32'(bus.res_data), 32'h40);
      handshake();
`endif
      check("t6_op_count", 32'(op_count), 32'(exp_cnt));

      // Randomized 256-op run from reset: data vs reference, op_count wraps to 0
      do_reset();
      for (int i = 0; i < 256; i++) begin
         run_op(rand_fp8(), rand_fp8(), int'($urandom_range(0, 2)));
      end
      check("wrap_op_count", 32'(op_count), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
